// File: rtl/fft_butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly for a 16-point in-place FFT: address gen + twiddle ROM,
// rounded complex product, then add/subtract. Optional macro BFLY_SCALE_EN halves results per stage.
module fft_butterfly_pipe #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [3:0]    in_stage,
    input  logic [AW-2:0] in_pair,
    input  logic [DW-1:0] in_a_re,
    input  logic [DW-1:0] in_a_im,
    input  logic [DW-1:0] in_b_re,
    input  logic [DW-1:0] in_b_im,
    output logic          out_valid,
    output logic [AW-1:0] out_addr_a,
    output logic [AW-1:0] out_addr_b,
    output logic [DW-1:0] out_x_re,
    output logic [DW-1:0] out_x_im,
    output logic [DW-1:0] out_y_re,
    output logic [DW-1:0] out_y_im,
    output logic          out_ovf,
    output logic          ovf_sticky,
    output logic          busy
);
    localparam int STAGES = 3;
    localparam int PW     = 2*DW + 1;
    localparam logic signed [PW-1:0] MAXV = PW'((2**(DW-1)) - 1);
    localparam logic signed [PW-1:0] MINV = PW'(-(2**(DW-1)));
    localparam logic signed [PW-1:0] RND  = PW'(2**(DW-2));

    // Returns {saturated, value}.
    function automatic logic [DW:0] sat(input logic signed [PW-1:0] v);
        if (v > MAXV)
            return {1'b1, MAXV[DW-1:0]};
        else if (v < MINV)
            return {1'b1, MINV[DW-1:0]};
        else
            return {1'b0, v[DW-1:0]};
    endfunction

    function automatic logic signed [DW-1:0] tw(input int v);
        return DW'(v);
    endfunction

    logic [STAGES:1] vld_pipe;
    logic            accept;

    assign accept    = in_valid && (int'(in_stage) < AW);
    assign out_valid = vld_pipe[STAGES];
    assign busy      = |vld_pipe;

    // ---------------- address generation and twiddle lookup ----------------
    logic [AW-1:0] h, j, grp, addr_a_c, addr_b_c;
    logic [3:0]    tw_sh;
    logic [AW-2:0] k_c;
    logic signed [DW-1:0] w_re_c, w_im_c;

    always_comb begin
        h        = AW'(1) << in_stage;
        j        = {1'b0, in_pair} & (h - AW'(1));
        grp      = {1'b0, in_pair} >> in_stage;
        addr_a_c = (grp << (in_stage + 4'd1)) + j;
        addr_b_c = addr_a_c + h;
        tw_sh    = 4'(AW-1) - in_stage;
        k_c      = (AW-1)'(j << tw_sh);
    end

    // W_k = cos(2*pi*k/16) - j*sin(2*pi*k/16), Q1.15 constants
    always_comb begin
        w_re_c = tw(32767);
        w_im_c = tw(0);
        case (int'(k_c))
            1: begin w_re_c = tw(30274);  w_im_c = tw(-12540); end
            2: begin w_re_c = tw(23170);  w_im_c = tw(-23170); end
            3: begin w_re_c = tw(12540);  w_im_c = tw(-30274); end
            4: begin w_re_c = tw(0);      w_im_c = tw(-32767); end
            5: begin w_re_c = tw(-12540); w_im_c = tw(-30274); end
            6: begin w_re_c = tw(-23170); w_im_c = tw(-23170); end
            7: begin w_re_c = tw(-30274); w_im_c = tw(-12540); end
            default: ;
        endcase
    end

    // ---------------- P1 -> P2: T = B*W, rounded half-up then saturated ----------------
    logic signed [DW-1:0] a_re1, a_im1, b_re1, b_im1, w_re1, w_im1;
    logic [AW-1:0]        aa1, ab1;
    logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x, p_re, p_im;
    logic [DW:0]          t_re_s, t_im_s;

    always_comb begin
        br_x   = b_re1;
        bi_x   = b_im1;
        wr_x   = w_re1;
        wi_x   = w_im1;
        p_re   = (br_x*wr_x - bi_x*wi_x + RND) >>> (DW-1);
        p_im   = (br_x*wi_x + bi_x*wr_x + RND) >>> (DW-1);
        t_re_s = sat(p_re);
        t_im_s = sat(p_im);
    end

    // ---------------- P2 -> P3: X = A + T, Y = A - T ----------------
    logic signed [DW-1:0] a_re2, a_im2, t_re2, t_im2;
    logic [AW-1:0]        aa2, ab2;
    logic                 tovf2;
    logic signed [DW:0]   sx_re, sx_im, sy_re, sy_im;
    logic signed [DW-1:0] x_re_c, x_im_c, y_re_c, y_im_c;
    logic                 ovf_c;

`ifdef BFLY_SCALE_EN
    localparam logic signed [DW:0] ONE = 1;

    always_comb begin
        sx_re  = a_re2 + t_re2;
        sx_im  = a_im2 + t_im2;
        sy_re  = a_re2 - t_re2;
        sy_im  = a_im2 - t_im2;
        // halving the DW+1 sum always fits DW, so only T can saturate
        x_re_c = DW'((sx_re + ONE) >>> 1);
        x_im_c = DW'((sx_im + ONE) >>> 1);
        y_re_c = DW'((sy_re + ONE) >>> 1);
        y_im_c = DW'((sy_im + ONE) >>> 1);
        ovf_c  = tovf2;
    end
`else
    logic [DW:0] xr_s, xi_s, yr_s, yi_s;

    always_comb begin
        sx_re  = a_re2 + t_re2;
        sx_im  = a_im2 + t_im2;
        sy_re  = a_re2 - t_re2;
        sy_im  = a_im2 - t_im2;
        xr_s   = sat(sx_re);
        xi_s   = sat(sx_im);
        yr_s   = sat(sy_re);
        yi_s   = sat(sy_im);
        x_re_c = xr_s[DW-1:0];
        x_im_c = xi_s[DW-1:0];
        y_re_c = yr_s[DW-1:0];
        y_im_c = yi_s[DW-1:0];
        ovf_c  = tovf2 | xr_s[DW] | xi_s[DW] | yr_s[DW] | yi_s[DW];
    end
`endif

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe   <= '0;
            a_re1      <= '0; a_im1 <= '0; b_re1 <= '0; b_im1 <= '0;
            w_re1      <= '0; w_im1 <= '0; aa1   <= '0; ab1   <= '0;
            a_re2      <= '0; a_im2 <= '0; t_re2 <= '0; t_im2 <= '0;
            aa2        <= '0; ab2   <= '0; tovf2 <= 1'b0;
            out_addr_a <= '0; out_addr_b <= '0;
            out_x_re   <= '0; out_x_im   <= '0;
            out_y_re   <= '0; out_y_im   <= '0;
            out_ovf    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            // data registers only move with a valid op, so outputs hold between results
            if (accept) begin
                a_re1 <= in_a_re;  a_im1 <= in_a_im;
                b_re1 <= in_b_re;  b_im1 <= in_b_im;
                w_re1 <= w_re_c;   w_im1 <= w_im_c;
                aa1   <= addr_a_c; ab1   <= addr_b_c;
            end
            if (vld_pipe[1]) begin
                a_re2 <= a_re1; a_im2 <= a_im1;
                t_re2 <= t_re_s[DW-1:0];
                t_im2 <= t_im_s[DW-1:0];
                tovf2 <= t_re_s[DW] | t_im_s[DW];
                aa2   <= aa1;   ab2   <= ab1;
            end
            if (vld_pipe[2]) begin
                out_addr_a <= aa2;    out_addr_b <= ab2;
                out_x_re   <= x_re_c; out_x_im   <= x_im_c;
                out_y_re   <= y_re_c; out_y_im   <= y_im_c;
            end
            out_ovf    <= vld_pipe[2] & ovf_c;
            ovf_sticky <= ovf_sticky | (vld_pipe[2] & ovf_c);
        end
    end

endmodule

// File: tb/tb_fft_butterfly_pipe.sv
// Scoreboarded bench for fft_butterfly_pipe: vector table, back-to-back stage-2 sweep,
// invalid-stage drop and reset with ops in flight. Honors BFLY_SCALE_EN for expected values.
module tb_fft_butterfly_pipe;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [3:0]    in_stage = '0;
    logic [AW-2:0] in_pair = '0;
    logic [DW-1:0] in_a_re = '0, in_a_im = '0, in_b_re = '0, in_b_im = '0;
    logic          out_valid, out_ovf, ovf_sticky, busy;
    logic [AW-1:0] out_addr_a, out_addr_b;
    logic [DW-1:0] out_x_re, out_x_im, out_y_re, out_y_im;

    fft_butterfly_pipe #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_stage(in_stage), .in_pair(in_pair),
        .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
        .out_valid(out_valid), .out_addr_a(out_addr_a), .out_addr_b(out_addr_b),
        .out_x_re(out_x_re), .out_x_im(out_x_im), .out_y_re(out_y_re), .out_y_im(out_y_im),
        .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stage, pair, ar, ai, br, bi;
        int aa, ab, xr, xi, yr, yi, ovf;
    } vec_t;

    typedef struct {
        int aa, ab, xr, xi, yr, yi, ovf, cyc;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp = '{default: 0};
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    int TWR[8] = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274};
    int TWI[8] = '{0, -12540, -23170, -30274, -32767, -30274, -23170, -12540};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat16(input longint v, inout int o);
        if (v > 32767) begin o = 1; return 32767; end
        if (v < -32768) begin o = 1; return -32768; end
        return int'(v);
    endfunction

    // Reference butterfly from the arithmetic definition, used for the random sweep.
    function automatic exp_t model(input int k, ar, ai, br, bi, aa, ab);
        exp_t   e;
        longint pr, pi;
        int     tr, ti, o;
        o  = 0;
        pr = longint'(br)*TWR[k] - longint'(bi)*TWI[k];
        pi = longint'(br)*TWI[k] + longint'(bi)*TWR[k];
        tr = sat16((pr + 16384) >>> 15, o);
        ti = sat16((pi + 16384) >>> 15, o);
`ifdef BFLY_SCALE_EN
        e.xr = (ar + tr + 1) >>> 1;
        e.xi = (ai + ti + 1) >>> 1;
        e.yr = (ar - tr + 1) >>> 1;
        e.yi = (ai - ti + 1) >>> 1;
`else
        e.xr = sat16(longint'(ar + tr), o);
        e.xi = sat16(longint'(ai + ti), o);
        e.yr = sat16(longint'(ar - tr), o);
        e.yi = sat16(longint'(ai - ti), o);
`endif
        e.ovf = o;
        e.aa  = aa;
        e.ab  = ab;
        e.cyc = 0;
        return e;
    endfunction

    function automatic vec_t mkv(input int s, p, ar, ai, br, bi, aa, ab,
                                 xr, xi, yr, yi, ovf);
        vec_t v;
        v.stage = s; v.pair = p; v.ar = ar; v.ai = ai; v.br = br; v.bi = bi;
        v.aa = aa; v.ab = ab; v.xr = xr; v.xi = xi; v.yr = yr; v.yi = yi; v.ovf = ovf;
        return v;
    endfunction

    task automatic send(input int s, p, ar, ai, br, bi, input bit push, input exp_t e);
        in_valid = 1'b1;
        in_stage = 4'(s);
        in_pair  = (AW-1)'(p);
        in_a_re  = DW'(ar); in_a_im = DW'(ai);
        in_b_re  = DW'(br); in_b_im = DW'(bi);
        if (push) begin
            e.cyc = cyc + 3;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin idle(); n++; end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s drain: %0d results missing, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %b required %b", name, got, req);
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (out_valid !== 1'b0 || out_ovf !== 1'b0 || ovf_sticky !== 1'b0 || busy !== 1'b0 ||
            out_addr_a !== '0 || out_addr_b !== '0 || out_x_re !== '0 || out_x_im !== '0 ||
            out_y_re !== '0 || out_y_im !== '0) begin
            fails++;
            $display("FAIL %s: v=%b ovf=%b st=%b busy=%b aa=%0d ab=%0d x=(%0d,%0d) y=(%0d,%0d), required all 0",
                     name, out_valid, out_ovf, ovf_sticky, busy, out_addr_a, out_addr_b,
                     $signed(out_x_re), $signed(out_x_im), $signed(out_y_re), $signed(out_y_im));
        end
    endtask

    // Monitor: pops expected results on out_valid, checks hold value otherwise.
    always @(negedge clk) begin
        exp_t e;
        int   xr, xi, yr, yi;
        xr = int'($signed(out_x_re)); xi = int'($signed(out_x_im));
        yr = int'($signed(out_y_re)); yi = int'($signed(out_y_im));
        if (!reset) begin
            tests++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out_valid at cycle %0d: aa=%0d, required no output", cyc, out_addr_a);
                end else begin
                    e = sb.pop_front();
                    last_exp = e;
                    if (cyc != e.cyc || int'(out_addr_a) != e.aa || int'(out_addr_b) != e.ab ||
                        xr != e.xr || xi != e.xi || yr != e.yr || yi != e.yi || int'(out_ovf) != e.ovf) begin
                        fails++;
                        $display("FAIL result: got cyc=%0d aa=%0d ab=%0d x=(%0d,%0d) y=(%0d,%0d) ovf=%0d, required cyc=%0d aa=%0d ab=%0d x=(%0d,%0d) y=(%0d,%0d) ovf=%0d",
                                 cyc, out_addr_a, out_addr_b, xr, xi, yr, yi, out_ovf,
                                 e.cyc, e.aa, e.ab, e.xr, e.xi, e.yr, e.yi, e.ovf);
                    end
                end
            end else if (int'(out_addr_a) != last_exp.aa || int'(out_addr_b) != last_exp.ab ||
                         xr != last_exp.xr || xi != last_exp.xi || yr != last_exp.yr ||
                         yi != last_exp.yi || out_ovf !== 1'b0) begin
                fails++;
                $display("FAIL hold at cycle %0d: got aa=%0d ab=%0d x=(%0d,%0d) y=(%0d,%0d) ovf=%0d, required aa=%0d ab=%0d x=(%0d,%0d) y=(%0d,%0d) ovf=0",
                         cyc, out_addr_a, out_addr_b, xr, xi, yr, yi, out_ovf,
                         last_exp.aa, last_exp.ab, last_exp.xr, last_exp.xi, last_exp.yr, last_exp.yi);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        exp_t e;
        int   AA2[8] = '{0, 1, 2, 3, 8, 9, 10, 11};
        int   AB2[8] = '{4, 5, 6, 7, 12, 13, 14, 15};

`ifdef BFLY_SCALE_EN
        vecs[0] = mkv(0, 0,  16384,      0,   8192,      0,  0,  1,  12288,      0,   4096,      0, 0);
        vecs[1] = mkv(1, 3,      0,      0,  16384,      0,  5,  7,      0,  -8191,      0,   8192, 0);
        vecs[2] = mkv(0, 0,  30000,      0,  10000,      0,  0,  1,  20000,      0,  10000,      0, 0);
        vecs[3] = mkv(3, 5,      0,      0,  16384,      0,  5, 13,  -3135,  -7568,   3135,   7569, 0);
        vecs[4] = mkv(2, 1,      0,      0, -32768, -32768,  1,  5, -16384,      0,  16384,      0, 1);
        vecs[5] = mkv(3, 1,  -1000,   2000,      0,  16384,  1,  9,   2635,   8569,  -3635,  -6568, 0);
        vecs[6] = mkv(0, 7, -30000, -30000,  10000, -10000, 14, 15, -10000, -20000, -20000, -10000, 0);
`else
        vecs[0] = mkv(0, 0,  16384,      0,   8192,      0,  0,  1,  24576,      0,   8192,      0, 0);
        vecs[1] = mkv(1, 3,      0,      0,  16384,      0,  5,  7,      0, -16383,      0,  16383, 0);
        vecs[2] = mkv(0, 0,  30000,      0,  10000,      0,  0,  1,  32767,      0,  20000,      0, 1);
        vecs[3] = mkv(3, 5,      0,      0,  16384,      0,  5, 13,  -6270, -15137,   6270,  15137, 0);
        vecs[4] = mkv(2, 1,      0,      0, -32768, -32768,  1,  5, -32768,      0,  32767,      0, 1);
        vecs[5] = mkv(3, 1,  -1000,   2000,      0,  16384,  1,  9,   5270,  17137,  -7270, -13137, 0);
        vecs[6] = mkv(0, 7, -30000, -30000,  10000, -10000, 14, 15, -20000, -32768, -32768, -20000, 1);
`endif

        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // table vectors, issued back to back
        foreach (vecs[i]) begin
            e = '{aa: vecs[i].aa, ab: vecs[i].ab, xr: vecs[i].xr, xi: vecs[i].xi,
                  yr: vecs[i].yr, yi: vecs[i].yi, ovf: vecs[i].ovf, cyc: 0};
            send(vecs[i].stage, vecs[i].pair, vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi, 1'b1, e);
        end
        drain("table");
        check_bit("ovf_sticky_set", ovf_sticky, 1'b1);

        // stage 2, pairs 0..7 on consecutive cycles with random operands
        for (int p = 0; p < 8; p++) begin
            int ar, ai, br, bi;
            ar = int'($urandom_range(65535)) - 32768;
            ai = int'($urandom_range(65535)) - 32768;
            br = int'($urandom_range(65535)) - 32768;
            bi = int'($urandom_range(65535)) - 32768;
            e  = model((p & 3) << 1, ar, ai, br, bi, AA2[p], AB2[p]);
            send(2, p, ar, ai, br, bi, 1'b1, e);
        end
        drain("stage2_sweep");
        repeat (2) idle();

        // invalid stages are dropped; monitor flags any out_valid
        send(4, 0, 100, 100, 100, 100, 1'b0, e);
        send(15, 3, 100, 100, 100, 100, 1'b0, e);
        for (int i = 0; i < 4; i++) begin
            check_bit("invalid_stage_busy", busy, 1'b0);
            idle();
        end

        // reset with three ops in the pipeline
        e = '{default: 0};
        in_valid = 1'b1; in_stage = 4'd0; in_pair = '0;
        in_a_re = DW'(1000); in_a_im = '0; in_b_re = DW'(2000); in_b_im = '0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        in_valid = 1'b0;
        last_exp = '{default: 0};
        #1;
        check_zero("reset_midop");
        @(negedge clk);
        reset = 1'b0;
        repeat (6) idle();
        check_bit("busy_after_reset", busy, 1'b0);

        // first op after reset: three-cycle latency, sticky stays clear
        e = '{aa: vecs[0].aa, ab: vecs[0].ab, xr: vecs[0].xr, xi: vecs[0].xi,
              yr: vecs[0].yr, yi: vecs[0].yi, ovf: vecs[0].ovf, cyc: 0};
        send(vecs[0].stage, vecs[0].pair, vecs[0].ar, vecs[0].ai, vecs[0].br, vecs[0].bi, 1'b1, e);
        drain("post_reset");
        check_bit("ovf_sticky_clear", ovf_sticky, 1'b0);
        repeat (2) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
